ewb_multi: RTL and testbench



---
 rtl/ewb_multi.sv | 225 ++++++++++++++++++++++
 tb/tb_ewb_multi.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ewb_multi.sv
// Eviction write buffer: a FIFO of up to DEPTH dirty lines sitting between the
// L1 memory port and the next level. Evictions are absorbed and coalesced,
// reads that hit a buffered line are served locally, and lines drain to
// memory oldest-first once the port has been idle for DRAIN_DELAY cycles.
module ewb_multi #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned LINE_W      = 256,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned OFFSET_W    = 5,
    parameter int unsigned DRAIN_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ewb_read,
    input  logic              ewb_write,
    input  logic [ADDR_W-1:0] ewb_addr,
    input  logic [LINE_W-1:0] ewb_wdata,
    output logic [LINE_W-1:0] ewb_rdata,
    output logic              ewb_resp,
    output logic              ewb_full,
    output logic              ewb_empty,
    input  logic [LINE_W-1:0] line_o,
    output logic [LINE_W-1:0] line_i,
    input  logic              resp_o,
    output logic [ADDR_W-1:0] address_i,
    output logic              read_i,
    output logic              write_i
);

    localparam int unsigned TAG_W = ADDR_W - OFFSET_W;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned DLY_W = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESP    = 3'd1,
        S_RD_MEM  = 3'd2,
        S_RD_DONE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [TAG_W-1:0]   r_tag  [DEPTH];
    logic [LINE_W-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [DLY_W-1:0]   r_dly;

    logic               r_resp;
    logic               r_read;
    logic               r_write;
    logic               r_full;
    logic               r_empty;
    logic [ADDR_W-1:0]  r_addr;
    logic [LINE_W-1:0]  r_line;
    logic [LINE_W-1:0]  r_rdata;

    logic [TAG_W-1:0]   w_req_tag;
    logic               w_hit;
    logic [PTR_W-1:0]   w_hit_idx;
    logic               w_is_full;
    logic               w_do_ovw;
    logic               w_do_enq;
    logic               w_do_rhit;
    logic               w_do_deq;
    logic [DLY_W-1:0]   w_dly_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_unused_ok;

    assign w_req_tag   = ewb_addr[ADDR_W-1:OFFSET_W];
    assign w_is_full   = (r_count == CNT_W'(DEPTH));
    assign w_unused_ok = ^ewb_addr[OFFSET_W-1:0];

    assign ewb_rdata = r_rdata;
    assign ewb_resp  = r_resp;
    assign ewb_full  = r_full;
    assign ewb_empty = r_empty;
    assign line_i    = r_line;
    assign address_i = r_addr;
    assign read_i    = r_read;
    assign write_i   = r_write;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Associative tag lookup; coalescing keeps it to at most one hit
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_tag[i] == w_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_idx = PTR_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: writes beat reads, requests beat background drain
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (ewb_write) begin
                    w_state_nxt = (w_hit || !w_is_full) ? S_RESP : S_DRAIN;
                end else if (ewb_read) begin
                    w_state_nxt = w_hit ? S_RESP : S_RD_MEM;
                end else if ((r_count != '0) && (r_dly == DLY_W'(DRAIN_DELAY))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_RESP:    w_state_nxt = S_IDLE;
            S_RD_MEM:  if (resp_o) w_state_nxt = S_RD_DONE;
            S_RD_DONE: w_state_nxt = S_IDLE;
            S_DRAIN:   if (resp_o) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Per-state actions on the buffer and the drain-delay counter
    always_comb begin
        w_do_ovw  = 1'b0;
        w_do_enq  = 1'b0;
        w_do_rhit = 1'b0;
        w_do_deq  = 1'b0;
        w_dly_nxt = r_dly;
        case (r_state)
            S_IDLE: begin
                if (ewb_write || ewb_read) begin
                    w_dly_nxt = '0;
                    if (ewb_write) begin
                        if (w_hit)           w_do_ovw = 1'b1;
                        else if (!w_is_full) w_do_enq = 1'b1;
                    end else if (w_hit) begin
                        w_do_rhit = 1'b1;
                    end
                end else if (r_count != '0) begin
                    if (r_dly != DLY_W'(DRAIN_DELAY)) w_dly_nxt = r_dly + DLY_W'(1);
                end else begin
                    w_dly_nxt = '0;
                end
            end
            S_DRAIN: begin
                if (resp_o) begin
                    w_do_deq  = 1'b1;
                    w_dly_nxt = '0;
                end
            end
            default: ;
        endcase
        w_count_nxt = r_count;
        if (w_do_enq)      w_count_nxt = r_count + CNT_W'(1);
        else if (w_do_deq) w_count_nxt = r_count - CNT_W'(1);
    end

    // Control registers, pointers and registered port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_dly   <= '0;
            r_resp  <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_addr  <= '0;
            r_line  <= '0;
            r_rdata <= '0;
        end else begin
            r_dly   <= w_dly_nxt;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_resp  <= (w_state_nxt == S_RESP) || (w_state_nxt == S_RD_DONE);
            r_read  <= (w_state_nxt == S_RD_MEM);
            r_write <= (w_state_nxt == S_DRAIN);
            if (w_do_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= ptr_inc(r_tail);
            end
            if (w_do_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= ptr_inc(r_head);
            end
            if (w_do_rhit) begin
                r_rdata <= r_data[w_hit_idx];
            end else if ((r_state == S_RD_MEM) && resp_o) begin
                r_rdata <= line_o;
            end
            if ((r_state == S_IDLE) && (w_state_nxt == S_RD_MEM)) begin
                r_addr <= {w_req_tag, {OFFSET_W{1'b0}}};
            end
            if ((r_state == S_IDLE) && (w_state_nxt == S_DRAIN)) begin
                r_addr <= {r_tag[r_head], {OFFSET_W{1'b0}}};
                r_line <= r_data[r_head];
            end
        end
    end

    // Line storage; contents are only meaningful where the valid bit is set
    always_ff @(posedge clk) begin
        if (w_do_enq) begin
            r_tag[r_tail]  <= w_req_tag;
            r_data[r_tail] <= ewb_wdata;
        end
        if (w_do_ovw) begin
            r_data[w_hit_idx] <= ewb_wdata;
        end
    end

endmodule

// File: tb/tb_ewb_multi.sv
// Directed bench for ewb_multi with a fixed-latency memory responder.
module tb_ewb_multi;

    localparam int unsigned LW = 256;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ewb_read;
    logic          ewb_write;
    logic [AW-1:0] ewb_addr;
    logic [LW-1:0] ewb_wdata;
    logic [LW-1:0] ewb_rdata;
    logic          ewb_resp;
    logic          ewb_full;
    logic          ewb_empty;
    logic [LW-1:0] line_o;
    logic [LW-1:0] line_i;
    logic          resp_o;
    logic [AW-1:0] address_i;
    logic          read_i;
    logic          write_i;

    int n_cmp     = 0;
    int n_err     = 0;
    int n_overlap = 0;
    int n_rd_cyc  = 0;
    int mem_lat   = 0;

    logic [AW-1:0] q_addr[$];
    logic [LW-1:0] q_data[$];

    ewb_multi #(
        .DEPTH(4), .LINE_W(LW), .ADDR_W(AW), .OFFSET_W(5), .DRAIN_DELAY(2)
    ) dut (
        .clk(clk), .rst(rst),
        .ewb_read(ewb_read), .ewb_write(ewb_write), .ewb_addr(ewb_addr),
        .ewb_wdata(ewb_wdata), .ewb_rdata(ewb_rdata), .ewb_resp(ewb_resp),
        .ewb_full(ewb_full), .ewb_empty(ewb_empty),
        .line_o(line_o), .line_i(line_i), .resp_o(resp_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i)
    );

    always #5 clk = ~clk;

    // Memory: answers a held read/write on the 3rd negedge, logs writes
    always @(negedge clk) begin
        if (rst) begin
            resp_o  = 1'b0;
            mem_lat = 0;
        end else if (resp_o) begin
            resp_o  = 1'b0;
            mem_lat = 0;
        end else if (read_i || write_i) begin
            mem_lat = mem_lat + 1;
            if (mem_lat == 3) begin
                resp_o = 1'b1;
                if (write_i) begin
                    q_addr.push_back(address_i);
                    q_data.push_back(line_i);
                end else begin
                    line_o = {8{address_i}};
                end
            end
        end else begin
            mem_lat = 0;
        end
    end

    always @(posedge clk) begin
        if (read_i && write_i) n_overlap++;
        if (read_i) n_rd_cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [LW-1:0] pat(input logic [31:0] w);
        return {8{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // sel: 0=write_i 1=read_i 2=ewb_resp 3=ewb_empty
    task automatic wait_until(input string tag, input int sel, input logic val,
                              input int budget, output int waited);
        bit   seen;
        logic cur;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < budget) begin
            tick();
            waited++;
            case (sel)
                0:       cur = write_i;
                1:       cur = read_i;
                2:       cur = ewb_resp;
                default: cur = ewb_empty;
            endcase
            seen = (cur === val);
        end
        n_cmp++;
        assert (seen === 1'b1) else begin
            n_err++;
            $error("FAIL %s: observed no event in %0d cycles, required %b", tag, waited, val);
        end
    endtask

    // Hold a request until ewb_resp, drop it, and step into the next IDLE cycle
    task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d,
                          input string tag, output int lat, output logic [LW-1:0] rd);
        ewb_write = wr;
        ewb_read  = !wr;
        ewb_addr  = a;
        ewb_wdata = d;
        wait_until(tag, 2, 1'b1, 150, lat);
        rd        = ewb_rdata;
        ewb_write = 1'b0;
        ewb_read  = 1'b0;
        tick();
    endtask

    initial begin
        int            lat;
        int            w;
        int            base;
        int            rd_before;
        logic [LW-1:0] rd;
        logic [AW-1:0] exp_a;

        rst = 1'b1; ewb_read = 1'b0; ewb_write = 1'b0;
        ewb_addr = '0; ewb_wdata = '0; line_o = '0; resp_o = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_empty", LW'(ewb_empty), 1);
        chk("rst_full",  LW'(ewb_full), 0);
        chk("rst_resp",  LW'(ewb_resp), 0);
        chk("rst_wr",    LW'(write_i), 0);
        chk("rst_rd",    LW'(read_i), 0);
        chk("rst_addr",  LW'(address_i), 0);
        chk("rst_line",  line_i, 0);
        chk("rst_rdata", ewb_rdata, 0);
        rst = 1'b0;
        tick();

        // Single eviction then background drain after two idle cycles
        do_req(1'b1, 32'h0000_1040, pat(32'hAAAA_AAAA), "t1_resp", lat, rd);
        chk("t1_lat", LW'(lat), 1);
        chk("t1_nonempty", LW'(ewb_empty), 0);
        tick();
        tick();
        chk("t1_no_early_drain", LW'(write_i), 0);
        tick();
        chk("t1_drain_wr", LW'(write_i), 1);
        chk("t1_drain_addr", LW'(address_i), 32'h0000_1040);
        chk("t1_drain_line", line_i, pat(32'hAAAA_AAAA));
        wait_until("t1_empty", 3, 1'b1, 20, w);
        chk("t1_wr_dropped", LW'(write_i), 0);
        chk("t1_log_n", LW'(q_addr.size()), 1);

        // Read hit on a buffered line, different offset
        do_req(1'b1, 32'h0000_1040, pat(32'hAAAA_AAAA), "t2_wr", lat, rd);
        rd_before = n_rd_cyc;
        do_req(1'b0, 32'h0000_105C, '0, "t2_rd", lat, rd);
        chk("t2_lat", LW'(lat), 1);
        chk("t2_rdata", rd, pat(32'hAAAA_AAAA));
        chk("t2_no_mem_rd", LW'(n_rd_cyc - rd_before), 0);
        wait_until("t2_empty", 3, 1'b1, 30, w);

        // Coalesce two back-to-back evictions of one line
        base = q_addr.size();
        do_req(1'b1, 32'h0000_2000, pat(32'hD1D1_D1D1), "t3_wr1", lat, rd);
        do_req(1'b1, 32'h0000_2010, pat(32'hD2D2_D2D2), "t3_wr2", lat, rd);
        chk("t3_lat2", LW'(lat), 1);
        wait_until("t3_empty", 3, 1'b1, 30, w);
        chk("t3_log_n", LW'(q_addr.size() - base), 1);
        if (q_addr.size() > base) begin
            chk("t3_addr", LW'(q_addr[base]), 32'h0000_2000);
            chk("t3_data", q_data[base], pat(32'hD2D2_D2D2));
        end

        // Fill all entries, then a fifth eviction forces a drain of the oldest
        base = q_addr.size();
        for (int k = 1; k <= 4; k++) begin
            exp_a = 32'h100 * k;
            do_req(1'b1, exp_a, pat(32'hD000_0000 | exp_a), "t4_fill", lat, rd);
        end
        chk("t4_full", LW'(ewb_full), 1);
        chk("t4_not_empty", LW'(ewb_empty), 0);
        ewb_write = 1'b1;
        ewb_addr  = 32'h0000_0500;
        ewb_wdata = pat(32'hD000_0500);
        tick();
        chk("t4_forced_wr", LW'(write_i), 1);
        chk("t4_forced_addr", LW'(address_i), 32'h0000_0100);
        chk("t4_no_resp", LW'(ewb_resp), 0);
        wait_until("t4_resp5", 2, 1'b1, 30, w);
        chk("t4_resp_after_drain", LW'(q_addr.size() - base), 1);
        chk("t4_full_again", LW'(ewb_full), 1);
        ewb_write = 1'b0;
        tick();
        wait_until("t4_empty", 3, 1'b1, 150, w);
        chk("t4_log_n", LW'(q_addr.size() - base), 5);
        if (q_addr.size() >= base + 5) begin
            for (int k = 0; k < 5; k++) begin
                exp_a = 32'h100 * (k + 1);
                chk("t4_order_addr", LW'(q_addr[base + k]), LW'(exp_a));
                chk("t4_order_data", q_data[base + k], pat(32'hD000_0000 | exp_a));
            end
        end

        // Read miss while two lines wait for the drain window
        base = q_addr.size();
        do_req(1'b1, 32'h0000_3000, pat(32'h3333_3333), "t5_wr1", lat, rd);
        do_req(1'b1, 32'h0000_4000, pat(32'h4444_4444), "t5_wr2", lat, rd);
        ewb_read = 1'b1;
        ewb_addr = 32'h0000_9004;
        tick();
        chk("t5_rd_i", LW'(read_i), 1);
        chk("t5_no_wr", LW'(write_i), 0);
        chk("t5_rd_addr", LW'(address_i), 32'h0000_9000);
        wait_until("t5_resp", 2, 1'b1, 20, w);
        chk("t5_rdata", ewb_rdata, pat(32'h0000_9000));
        chk("t5_rd_dropped", LW'(read_i), 0);
        ewb_read = 1'b0;
        tick();
        wait_until("t5_empty", 3, 1'b1, 60, w);
        chk("t5_log_n", LW'(q_addr.size() - base), 2);
        if (q_addr.size() >= base + 2) begin
            chk("t5_first", LW'(q_addr[base]), 32'h0000_3000);
            chk("t5_second", LW'(q_addr[base + 1]), 32'h0000_4000);
        end

        // Reset in the middle of a drain abandons it
        base = q_addr.size();
        do_req(1'b1, 32'h0000_5000, pat(32'h5555_5555), "t6_wr", lat, rd);
        wait_until("t6_drain_start", 0, 1'b1, 10, w);
        rst = 1'b1;
        tick();
        chk("t6_wr_cleared", LW'(write_i), 0);
        chk("t6_empty", LW'(ewb_empty), 1);
        chk("t6_resp", LW'(ewb_resp), 0);
        rst = 1'b0;
        do_req(1'b1, 32'h0000_6000, pat(32'h6666_6666), "t6_wr2", lat, rd);
        chk("t6_lat", LW'(lat), 1);
        chk("t6_nonempty", LW'(ewb_empty), 0);
        wait_until("t6_empty2", 3, 1'b1, 30, w);
        chk("t6_log_n", LW'(q_addr.size() - base), 1);
        if (q_addr.size() > base) begin
            chk("t6_addr", LW'(q_addr[base]), 32'h0000_6000);
            chk("t6_data", q_data[base], pat(32'h6666_6666));
        end

        chk("rd_wr_exclusive", LW'(n_overlap), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
